// File: rtl/placar_pkg.sv
// Shared types and constants for the placar_pontuacao scoreboard core.
// Holds the FSM state encoding, per-button point values and a helper
// that resolves simultaneous button edges to a single point value.
package placar_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    APPLY    = 2'd1,
    ALARM    = 2'd2,
    WAIT_REL = 2'd3
  } placar_state_t;

  localparam int PTS_W = 2;

  localparam logic [PTS_W-1:0] PTS_A = 2'd1;
  localparam logic [PTS_W-1:0] PTS_B = 2'd2;
  localparam logic [PTS_W-1:0] PTS_C = 2'd3;

  // Coincident edges resolve to the most valuable button (C > B > A).
  function automatic logic [PTS_W-1:0] sel_points(input logic c,
                                                  input logic b,
                                                  input logic a);
    logic [PTS_W-1:0] p;
    p = '0;
    if (c)      p = PTS_C;
    else if (b) p = PTS_B;
    else if (a) p = PTS_A;
    return p;
  endfunction

endpackage

// File: rtl/placar_pontuacao_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser plus registered rising-edge detector.
// Latency: input sampled at edge 0, rise pulse registered at edge 2 (one cycle).
// No backpressure: a held button produces exactly one rise pulse.
// Ports: clk, rst_n (async active-low), btn (raw async input),
//        level (synchronised level), rise (one-cycle edge pulse).
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta_q <= btn;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise   <= sync_q & ~prev_q;
    end
  end

  assign level = sync_q;

endmodule

// File: rtl/placar_pontuacao.sv
// placar_pontuacao: per-team basketball score registers driven by 1/2/3-point buttons.
// Latency: button first sampled at edge 0, score/upd_valid or buzzer/led update at edge 4.
// No backpressure: button edges arriving while an operation is in flight are dropped.
// Ports: clk, rst_n (async active-low), btn_a/btn_b/btn_c (raw buttons), sub (1=subtract),
//        team_sel (target team), clear (sync clear), scores (packed per team),
//        upd_valid (score-change pulse), buzzer (timed reject pulse), led (latched error).
// Build option: define PLACAR_SATURATE_EN to clamp overflowing adds at max instead of rejecting.
module placar_pontuacao
  import placar_pkg::*;
#(
  parameter  int SCORE_W     = 7,
  parameter  int N_TEAMS     = 2,
  parameter  int BUZZ_CYCLES = 25_000_000,
  localparam int TEAM_W      = (N_TEAMS > 1) ? $clog2(N_TEAMS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       btn_a,
  input  logic                       btn_b,
  input  logic                       btn_c,
  input  logic                       sub,
  input  logic [TEAM_W-1:0]          team_sel,
  input  logic                       clear,
  output logic [N_TEAMS*SCORE_W-1:0] scores,
  output logic                       upd_valid,
  output logic                       buzzer,
  output logic                       led
);

  localparam int CNT_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
  // Counter is loaded at the reject edge and buzzer drops when it has
  // drained to zero, giving exactly BUZZ_CYCLES high cycles.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BUZZ_CYCLES - 1);

  // ---------------- button conditioning ----------------
  logic lvl_a, lvl_b, lvl_c;
  logic rise_a, rise_b, rise_c;

  btn_sync_edge u_sync_a (.clk(clk), .rst_n(rst_n), .btn(btn_a), .level(lvl_a), .rise(rise_a));
  btn_sync_edge u_sync_b (.clk(clk), .rst_n(rst_n), .btn(btn_b), .level(lvl_b), .rise(rise_b));
  btn_sync_edge u_sync_c (.clk(clk), .rst_n(rst_n), .btn(btn_c), .level(lvl_c), .rise(rise_c));

  logic any_rise;
  logic any_level;
  assign any_rise  = rise_a | rise_b | rise_c;
  assign any_level = lvl_a | lvl_b | lvl_c;

  // ---------------- state ----------------
  placar_state_t      state_q;
  logic [SCORE_W-1:0] score_q [N_TEAMS];
  logic [PTS_W-1:0]   pts_q;
  logic               sub_q;
  logic [TEAM_W-1:0]  team_q;
  logic [CNT_W-1:0]   cnt_q;

  // ---------------- operation evaluation ----------------
  logic               team_ok;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W:0]   cur_ext;
  logic [SCORE_W:0]   pts_ext;
  logic [SCORE_W:0]   sum_ext;
  logic [SCORE_W:0]   diff_ext;
  logic               underflow;
  logic               overflow;
  logic               reject;
  logic [SCORE_W-1:0] new_score;

  // Out-of-range team selections never match, so team_ok doubles as the range check.
  always_comb begin
    team_ok   = 1'b0;
    cur_score = '0;
    for (int i = 0; i < N_TEAMS; i++) begin
      if (team_q == TEAM_W'(i)) begin
        team_ok   = 1'b1;
        cur_score = score_q[i];
      end
    end
  end

  // One extra bit of headroom exposes the add carry and keeps the subtract compare unsigned-safe.
  assign cur_ext   = {1'b0, cur_score};
  assign pts_ext   = {{(SCORE_W + 1 - PTS_W){1'b0}}, pts_q};
  assign sum_ext   = cur_ext + pts_ext;
  assign diff_ext  = cur_ext - pts_ext;
  assign underflow = pts_ext > cur_ext;
  assign overflow  = sum_ext[SCORE_W];

  always_comb begin
    reject    = !team_ok || (sub_q && underflow);
    new_score = sub_q ? diff_ext[SCORE_W-1:0] : sum_ext[SCORE_W-1:0];
`ifdef PLACAR_SATURATE_EN
    if (!sub_q && overflow) begin
      new_score = '1;
    end
`else
    if (!sub_q && overflow) begin
      reject = 1'b1;
    end
`endif
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pts_q     <= '0;
      sub_q     <= 1'b0;
      team_q    <= '0;
      cnt_q     <= '0;
      upd_valid <= 1'b0;
      buzzer    <= 1'b0;
      led       <= 1'b0;
      for (int i = 0; i < N_TEAMS; i++) begin
        score_q[i] <= '0;
      end
    end else begin
      upd_valid <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        buzzer  <= 1'b0;
        led     <= 1'b0;
        for (int i = 0; i < N_TEAMS; i++) begin
          score_q[i] <= '0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (any_rise) begin
              pts_q   <= sel_points(rise_c, rise_b, rise_a);
              sub_q   <= sub;
              team_q  <= team_sel;
              state_q <= APPLY;
            end
          end
          APPLY: begin
            if (reject) begin
              buzzer  <= 1'b1;
              led     <= 1'b1;
              cnt_q   <= CNT_INIT;
              state_q <= ALARM;
            end else begin
              for (int i = 0; i < N_TEAMS; i++) begin
                if (team_q == TEAM_W'(i)) begin
                  score_q[i] <= new_score;
                end
              end
              upd_valid <= 1'b1;
              led       <= 1'b0;
              state_q   <= WAIT_REL;
            end
          end
          ALARM: begin
            if (cnt_q == '0) begin
              buzzer  <= 1'b0;
              state_q <= WAIT_REL;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          WAIT_REL: begin
            if (!any_level) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    scores = '0;
    for (int i = 0; i < N_TEAMS; i++) begin
      scores[i*SCORE_W +: SCORE_W] = score_q[i];
    end
  end

endmodule
